rs232_tx_buffered: RTL and testbench
====================================

RS232_TX_BUFFERED -- requirements
Module: rs232_tx_buffered

Interface
REQ-001 Parameter CLOCK_FREQ, default 133000000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, line bit rate in bit/s.
REQ-003 Parameter FIFO_LOG2, default 4, log2 of the transmit FIFO depth (depth 16).
REQ-004 clock  input  1  the single clock; all logic on rising edge.
REQ-005 resetn  input  1  synchronous, active-low reset.
REQ-006 idata  input  8  AXI-stream byte to transmit.
REQ-007 ivalid  input  1  idata valid.
REQ-008 iready  output  1  FIFO can accept a byte.
REQ-009 txd_pin  output  1  serial line, idle high.
REQ-010 ctsn_pin  input  1  clear-to-send from peer, active low, asynchronous.
REQ-011 busy  output  1  high while the FIFO is non-empty or a frame is on the line.

Function
REQ-012 DIVISOR SHALL be (CLOCK_FREQ + BAUD_RATE/2) / BAUD_RATE; values below 2 SHALL be a elaboration-time error.
REQ-013 Every bit on txd_pin SHALL last exactly DIVISOR clock cycles.
REQ-014 Frame: start bit 0, 8 data bits LSB first, optional parity (REQ-028), one stop bit 1.
REQ-015 A byte SHALL be accepted only on a cycle with ivalid && iready; iready = !full.
REQ-016 When the FIFO is full, iready SHALL be low, and a byte offered that cycle SHALL NOT be written.
REQ-017 ctsn_pin SHALL pass through a 2-flop synchronizer before use.
REQ-018 FSM states are IDLE, START, DATA, PARITY, STOP.
- IDLE -> START: pop on FIFO non-empty && synchronized ctsn low.
- START -> DATA -> PARITY (if enabled) -> STOP: transition after DIVISOR cycles each; DATA spans 8 bits.
REQ-019 On the last cycle of STOP:
- go to START with a pop if the FIFO is non-empty && ctsn is low, with no idle gap;
- otherwise go to IDLE.
REQ-020 A frame in progress SHALL complete even if ctsn goes high mid-frame; ctsn is checked only at pop.
REQ-021 txd_pin SHALL be registered.
- The start bit SHALL appear 2 cycles after the accepting handshake when idle, FIFO empty and ctsn already synchronized low.
REQ-022 FIFO push and pop on the same cycle SHALL both take effect; the occupancy is unchanged.
REQ-023 busy SHALL be asserted from the cycle after a handshake until the cycle after the stop bit ends with the FIFO empty.

Reset
REQ-024 While resetn is low at a clock edge, the block SHALL reset to:
- FSM = IDLE, FIFO empty;
- txd_pin = 1, iready = 0, busy = 0;
- synchronizer flops = 1 (not clear).
REQ-025 iready SHALL go high on the first cycle after resetn is sampled high.
REQ-026 A reset asserted mid-frame SHALL abort the frame, drive txd_pin high on the next cycle and discard FIFO contents.

Configuration
REQ-027 Macro RS232_TX_PARITY_EN selects the parity option.
REQ-028 With the macro defined, an even parity bit (XOR of the 8 data bits) SHALL be sent between the data bits and the stop bit; the frame is 11 bits.
REQ-029 Without the macro, the PARITY state and its logic SHALL NOT exist; the frame is 10 bits.

Structure
REQ-030 The FSM state encoding and the DIVISOR computation function SHALL live in shared package rs232_pkg.
REQ-031 The FIFO SHALL be a separate sub-module axis_fifo (parameters WIDTH, LOG2), reusable by the receive path.

Verification (CLOCK_FREQ=16, BAUD_RATE=4, so DIVISOR=4; ctsn_pin=0 unless stated)
REQ-032 Send 0x55 -> txd 0,1,0,1,0,1,0,1,0,1 (no parity), each level 4 cycles; start bit 2 cycles after handshake.
REQ-033 With RS232_TX_PARITY_EN: send 0x01 -> parity bit 1; send 0x55 -> parity bit 0.
REQ-034 Push 17 bytes with ctsn_pin=1 -> iready low after 16, txd stays high; drop ctsn_pin -> all 16 bytes sent back-to-back, no idle gaps, in order.
REQ-035 Raise ctsn_pin in the middle of the data bits of 0xA3 -> that frame completes; the next byte is held until ctsn_pin is low again.
REQ-036 Assert resetn=0 during bit 3 of a frame -> txd_pin=1 next cycle, busy=0, iready=0; after release, iready=1 and the FIFO is empty.
REQ-037 Push and pop on the same cycle with the FIFO at 8 entries -> occupancy remains 8.

Source files
------------

// File: rtl/rs232_pkg.sv
// rs232_pkg: shared UART definitions -- transmitter FSM states and baud divisor.
// Define RS232_TX_PARITY_EN to add the PARITY state (even parity bit per frame).
package rs232_pkg;

   localparam int unsigned DATA_BITS = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef RS232_TX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } tx_state_t;

   // Clock cycles per line bit, rounded to nearest.
   function automatic int unsigned calc_divisor(input int unsigned clock_freq,
                                                input int unsigned baud_rate);
      return (clock_freq + baud_rate / 2) / baud_rate;
   endfunction

endpackage

// File: rtl/axis_fifo.sv
// axis_fifo: AXI-stream style synchronous FIFO, 2**LOG2 entries, registered flags.
// Shared by the UART transmit and receive paths.
module axis_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned LOG2  = 4
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic [WIDTH-1:0] idata,
   input  logic             ivalid,
   output logic             iready,
   output logic [WIDTH-1:0] odata,
   output logic             ovalid,
   input  logic             oready,
   output logic [LOG2:0]    count
);

   localparam int unsigned DEPTH = 1 << LOG2;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [LOG2-1:0]  wr_ptr;
   logic [LOG2-1:0]  rd_ptr;
   logic [LOG2:0]    count_d;
   logic             push;
   logic             pop;

   assign push  = ivalid && iready;
   assign pop   = oready && ovalid;
   assign odata = mem[rd_ptr];

   // Next occupancy; simultaneous push and pop leave it unchanged.
   always_comb begin
      count_d = count;
      case ({push, pop})
         2'b10:   count_d = count + (LOG2+1)'(1);
         2'b01:   count_d = count - (LOG2+1)'(1);
         default: count_d = count;
      endcase
   end

   // Storage array, written on accepted pushes.
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= idata;
      end
   end

   // Pointers, occupancy and registered ready/valid flags.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         iready <= 1'b0;
         ovalid <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + LOG2'(1);
         if (pop)  rd_ptr <= rd_ptr + LOG2'(1);
         count  <= count_d;
         iready <= (count_d != (LOG2+1)'(DEPTH));
         ovalid <= (count_d != '0);
      end
   end

endmodule

// File: rtl/rs232_tx_buffered.sv
// rs232_tx_buffered: FIFO-buffered RS-232 transmitter with CTS flow control.
// Frame: start 0, 8 data bits LSB first, [even parity with RS232_TX_PARITY_EN], stop 1.
module rs232_tx_buffered
   import rs232_pkg::*;
#(
   parameter int unsigned CLOCK_FREQ = 133000000,
   parameter int unsigned BAUD_RATE  = 115200,
   parameter int unsigned FIFO_LOG2  = 4
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic [7:0] idata,
   input  logic       ivalid,
   output logic       iready,
   output logic       txd_pin,
   input  logic       ctsn_pin,
   output logic       busy
);

   localparam int unsigned DIVISOR = calc_divisor(CLOCK_FREQ, BAUD_RATE);
   localparam int unsigned CNT_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
   localparam int unsigned BIT_W   = $clog2(DATA_BITS);

   if (DIVISOR < 2) begin : g_divisor_check
      $error("rs232_tx_buffered: baud divisor must be at least 2");
   end

   tx_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [BIT_W-1:0] bit_q, bit_d;
   logic [7:0]       shreg_q, shreg_d;
   logic             txd_d;
   logic             busy_d;
   logic             bit_end;
   logic             cts_meta, cts_sync;
   logic [7:0]       fifo_data;
   logic             fifo_valid;
   logic             fifo_pop;
   logic             fifo_push;
   logic             fifo_nonempty_d;
   logic [FIFO_LOG2:0] fifo_count;
`ifdef RS232_TX_PARITY_EN
   logic             parity_q, parity_d;
`endif

   axis_fifo #(
      .WIDTH (8),
      .LOG2  (FIFO_LOG2)
   ) u_fifo (
      .clock  (clock),
      .resetn (resetn),
      .idata  (idata),
      .ivalid (ivalid),
      .iready (iready),
      .odata  (fifo_data),
      .ovalid (fifo_valid),
      .oready (fifo_pop),
      .count  (fifo_count)
   );

   assign bit_end   = (cnt_q == CNT_W'(DIVISOR - 1));
   assign fifo_push = ivalid && iready;
   assign fifo_nonempty_d = fifo_push
                         || (fifo_count > (FIFO_LOG2+1)'(1))
                         || ((fifo_count == (FIFO_LOG2+1)'(1)) && !fifo_pop);
   assign busy_d = fifo_nonempty_d || (state_d != ST_IDLE);

   // Two-flop synchronizer for the asynchronous CTS input; idles deasserted.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         cts_meta <= 1'b1;
         cts_sync <= 1'b1;
      end else begin
         cts_meta <= ctsn_pin;
         cts_sync <= cts_meta;
      end
   end

   // Frame sequencer: next state, bit timing, FIFO pop and next line level.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shreg_d  = shreg_q;
      fifo_pop = 1'b0;
      txd_d    = 1'b1;
`ifdef RS232_TX_PARITY_EN
      parity_d = parity_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (fifo_valid && !cts_sync) begin
               fifo_pop = 1'b1;
               state_d  = ST_START;
               cnt_d    = '0;
               shreg_d  = fifo_data;
`ifdef RS232_TX_PARITY_EN
               parity_d = ^fifo_data;
`endif
            end
         end
         ST_START: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (bit_end) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (bit_end) begin
               cnt_d   = '0;
               shreg_d = {1'b0, shreg_q[7:1]};
               bit_d   = bit_q + BIT_W'(1);
               if (bit_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef RS232_TX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end
            end
         end
`ifdef RS232_TX_PARITY_EN
         ST_PARITY: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (bit_end) begin
               cnt_d   = '0;
               state_d = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (bit_end) begin
               cnt_d = '0;
               // Chain straight into the next frame when allowed, no idle gap.
               if (fifo_valid && !cts_sync) begin
                  fifo_pop = 1'b1;
                  state_d  = ST_START;
                  shreg_d  = fifo_data;
`ifdef RS232_TX_PARITY_EN
                  parity_d = ^fifo_data;
`endif
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      case (state_d)
         ST_START:  txd_d = 1'b0;
         ST_DATA:   txd_d = shreg_d[0];
`ifdef RS232_TX_PARITY_EN
         ST_PARITY: txd_d = parity_d;
`endif
         default:   txd_d = 1'b1;
      endcase
   end

   // State, counters, shift register and registered outputs.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         txd_pin <= 1'b1;
         busy    <= 1'b0;
`ifdef RS232_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         txd_pin <= txd_d;
         busy    <= busy_d;
`ifdef RS232_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

endmodule

// File: tb/tb_rs232_tx_buffered.sv
// tb_rs232_tx_buffered: self-checking bench, CLOCK_FREQ=16 / BAUD_RATE=4 (4 cycles per bit).
// Honours RS232_TX_PARITY_EN for the expected frame length and parity bit.
module tb_rs232_tx_buffered;

   localparam int DIV = 4;
`ifdef RS232_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif

   typedef struct packed {
      logic [7:0] data;
      logic       par;
   } vec_t;

   logic       clock = 1'b0;
   logic       resetn;
   logic [7:0] idata;
   logic       ivalid;
   logic       iready;
   logic       txd_pin;
   logic       ctsn_pin;
   logic       busy;

   int tests = 0;
   int fails = 0;
   logic [7:0] exp_q[$];

   rs232_tx_buffered #(
      .CLOCK_FREQ (16),
      .BAUD_RATE  (4),
      .FIFO_LOG2  (4)
   ) dut (
      .clock    (clock),
      .resetn   (resetn),
      .idata    (idata),
      .ivalid   (ivalid),
      .iready   (iready),
      .txd_pin  (txd_pin),
      .ctsn_pin (ctsn_pin),
      .busy     (busy)
   );

   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push_byte(input logic [7:0] d);
      idata  = d;
      ivalid = 1'b1;
      tick();
      ivalid = 1'b0;
   endtask

   // Advance until the line goes low (start bit), bounded by budget cycles.
   task automatic wait_start(input int budget, input string name);
      int n = 0;
      while (txd_pin !== 1'b0 && n < budget) begin
         tick();
         n++;
      end
      check({name, " start seen"}, int'(txd_pin === 1'b0), 1);
   endtask

   // Check one full frame from the current (start bit) cycle; returns on the cycle after stop.
   task automatic check_frame(input logic [7:0] d, input logic par, input string name);
      int bad = 0;
      for (int j = 0; j < FRAME_BITS; j++) begin
         logic e;
         if (j == 0)                    e = 1'b0;
         else if (j <= 8)               e = d[3'(j - 1)];
         else if (j == FRAME_BITS - 1)  e = 1'b1;
         else                           e = par;
         for (int k = 0; k < DIV; k++) begin
            if (txd_pin !== e) bad++;
            tick();
         end
      end
      check($sformatf("%s frame 0x%02h bad bit-cycles", name, d), bad, 0);
   endtask

   initial begin
      vec_t       vecs[6];
      logic [7:0] burst[16];
      logic [7:0] d;
      int         bad;

      vecs[0] = '{data: 8'h55, par: 1'b0};
      vecs[1] = '{data: 8'h01, par: 1'b1};
      vecs[2] = '{data: 8'hA3, par: 1'b0};
      vecs[3] = '{data: 8'hFF, par: 1'b0};
      vecs[4] = '{data: 8'h00, par: 1'b0};
      vecs[5] = '{data: 8'h80, par: 1'b1};

      resetn   = 1'b0;
      ivalid   = 1'b0;
      idata    = 8'h00;
      ctsn_pin = 1'b0;

      // Reset state and release.
      tick();
      tick();
      check("reset txd", int'(txd_pin), 1);
      check("reset iready", int'(iready), 0);
      check("reset busy", int'(busy), 0);
      resetn = 1'b1;
      tick();
      check("iready first cycle after release", int'(iready), 1);
      tick();
      tick();

      // Table: single bytes from idle, start bit two cycles after handshake.
      for (int i = 0; i < 6; i++) begin
         check("iready idle", int'(iready), 1);
         push_byte(vecs[i].data);
         check("txd high cycle after handshake", int'(txd_pin), 1);
         check("busy after handshake", int'(busy), 1);
         tick();
         check_frame(vecs[i].data, vecs[i].par, "table");
         check("busy after frame", int'(busy), 0);
         check("txd idle after frame", int'(txd_pin), 1);
      end

      // Fill with CTS deasserted, then drain back-to-back.
      ctsn_pin = 1'b1;
      repeat (3) tick();
      bad = 0;
      for (int i = 0; i < 17; i++) begin
         check($sformatf("iready before push %0d", i), int'(iready), int'(i < 16));
         d = 8'($urandom);
         if (i < 16) burst[i] = d;
         idata  = d;
         ivalid = 1'b1;
         tick();
         if (txd_pin !== 1'b1) bad++;
      end
      ivalid = 1'b0;
      repeat (20) begin
         if (txd_pin !== 1'b1) bad++;
         tick();
      end
      check("txd held high while ctsn high", bad, 0);
      check("iready low when full", int'(iready), 0);
      ctsn_pin = 1'b0;
      wait_start(10, "burst");
      for (int i = 0; i < 16; i++) check_frame(burst[i], ^burst[i], $sformatf("burst %0d", i));
      check("txd idle after burst", int'(txd_pin), 1);
      check("busy after burst", int'(busy), 0);

      // CTS raised mid-frame: frame completes, next byte held.
      push_byte(8'hA3);
      push_byte(8'h5C);
      wait_start(10, "cts");
      fork
         check_frame(8'hA3, 1'b0, "cts mid-frame");
         begin
            repeat (14) tick();
            ctsn_pin = 1'b1;
         end
      join
      bad = 0;
      repeat (30) begin
         if (txd_pin !== 1'b1) bad++;
         tick();
      end
      check("next byte held while ctsn high", bad, 0);
      check("busy with byte pending", int'(busy), 1);
      ctsn_pin = 1'b0;
      wait_start(10, "cts resume");
      check_frame(8'h5C, 1'b0, "cts resume");
      check("busy after resume", int'(busy), 0);

      // Reset during data bit 3 of a frame.
      push_byte(8'h00);
      wait_start(10, "reset");
      push_byte(8'h11);
      push_byte(8'h22);
      repeat (15) tick();
      check("txd low in bit 3", int'(txd_pin), 0);
      resetn = 1'b0;
      tick();
      check("txd after mid-frame reset", int'(txd_pin), 1);
      check("busy after mid-frame reset", int'(busy), 0);
      check("iready after mid-frame reset", int'(iready), 0);
      resetn = 1'b1;
      tick();
      check("iready after reset release", int'(iready), 1);
      check("fifo empty after reset", int'(dut.u_fifo.count), 0);
      bad = 0;
      repeat (30) begin
         if (txd_pin !== 1'b1 || busy !== 1'b0) bad++;
         tick();
      end
      check("line quiet after reset", bad, 0);

      // Push and pop on the same cycle at 8 entries.
      ctsn_pin = 1'b1;
      repeat (3) tick();
      for (int i = 0; i < 8; i++) begin
         burst[i] = 8'($urandom);
         push_byte(burst[i]);
      end
      check("occupancy 8", int'(dut.u_fifo.count), 8);
      ctsn_pin = 1'b0;
      tick();
      tick();
      burst[8] = 8'($urandom);
      push_byte(burst[8]);
      check("occupancy after push+pop", int'(dut.u_fifo.count), 8);
      check("start bit on pop cycle", int'(txd_pin), 0);
      for (int i = 0; i < 9; i++) check_frame(burst[i], ^burst[i], $sformatf("pushpop %0d", i));
      check("busy after pushpop", int'(busy), 0);

      // Randomized bursts with random gaps against a byte-queue model.
      for (int r = 0; r < 4; r++) begin
         int n;
         n = int'($urandom_range(16, 2));
         exp_q.delete();
         fork
            begin
               for (int i = 0; i < n; i++) begin
                  logic [7:0] v;
                  repeat ($urandom_range(6, 0)) tick();
                  v = 8'($urandom);
                  exp_q.push_back(v);
                  check("iready random", int'(iready), 1);
                  push_byte(v);
               end
            end
            begin
               for (int i = 0; i < n; i++) begin
                  logic [7:0] e;
                  wait_start(200, "random");
                  if (exp_q.size() == 0) begin
                     check("random frame without pushed byte", 1, 0);
                     e = 8'h00;
                  end else begin
                     e = exp_q.pop_front();
                  end
                  check_frame(e, ^e, $sformatf("random r%0d i%0d", r, i));
               end
            end
         join
         check("busy after random burst", int'(busy), 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
